// File: rtl/weight_pkg.sv
// weight_pkg: shared definitions for the weight loader and the weight ROM.
// Holds the load-sequence state enum, the default LSTM geometry, the
// region-length helpers and the address-width function.
package weight_pkg;

  // Load sequence: idle, then the four regions in file order
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WIH,
    ST_WHH,
    ST_BIH,
    ST_BHH
  } wload_state_e;

  // Default geometry: hidden size and input feature count
  localparam int COL_DEFAULT = 512;
  localparam int COW_DEFAULT = 96;
  localparam int QZ_DEFAULT  = 16;

  // Input-to-hidden weights: four gates of col x cow
  function automatic int wih_len(input int col, input int cow);
    return col * cow * 4;
  endfunction

  // Hidden-to-hidden weights: four gates of col x col
  function automatic int whh_len(input int col);
    return col * col * 4;
  endfunction

  // Each bias vector: four gates of col
  function automatic int bias_len(input int col);
    return col * 4;
  endfunction

  // Address width sized by the largest region (whh); assumes cow <= col
  function automatic int addr_w(input int col);
    return $clog2(col * col * 4);
  endfunction

endpackage

// File: rtl/wload_ctr.sv
// wload_ctr: word index counter for the active region. Wraps to zero on
// the terminal count so the next region starts at index 0 with no bubble.
module wload_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  assign count_o = count_q;
  assign tc_o    = (count_q == last_i);

  // Clear has priority; on an increment at terminal count wrap to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= tc_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams an LSTM weight file into four regions (wih, whh,
// bih, bhh) in file order, emitting one registered write per accepted word.
// Optional feature: define WLOAD_CHECKSUM_EN to keep a 32-bit running sum
// of accepted words; otherwise checksum is tied to zero.
module weight_loader
  import weight_pkg::*;
#(
  parameter int col = COL_DEFAULT,
  parameter int cow = COW_DEFAULT,
  parameter int QZ  = QZ_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [QZ-1:0]          s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   wr_wih,
  output logic                   wr_whh,
  output logic                   wr_bih,
  output logic                   wr_bhh,
  output logic [addr_w(col)-1:0] wr_addr,
  output logic [QZ-1:0]          wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            checksum
);

  localparam int AW = addr_w(col);
  localparam logic [AW-1:0] WIH_LAST  = AW'(wih_len(col, cow) - 1);
  localparam logic [AW-1:0] WHH_LAST  = AW'(whh_len(col) - 1);
  localparam logic [AW-1:0] BIAS_LAST = AW'(bias_len(col) - 1);

  wload_state_e  state_q;
  logic          busy_q;
  logic          wrWih_q, wrWhh_q, wrBih_q, wrBhh_q;
  logic [AW-1:0] wrAddr_q;
  logic [QZ-1:0] wrData_q;
  logic          done_q;

  logic          accept;
  logic          ctrClr;
  logic          ctrInc;
  logic          ctrTc;
  logic [AW-1:0] ctrCount;
  logic [AW-1:0] lastSel;

  // A beat transfers whenever the source is valid while a load is running
  assign accept = s_valid & busy_q;
  // Index sits at zero while idle and is dropped by abort
  assign ctrClr = (state_q == ST_IDLE) | abort;
  assign ctrInc = accept & ~abort;

  // Terminal index of the region currently being loaded
  always_comb begin
    lastSel = WIH_LAST;
    unique case (state_q)
      ST_WHH:  lastSel = WHH_LAST;
      ST_BIH:  lastSel = BIAS_LAST;
      ST_BHH:  lastSel = BIAS_LAST;
      default: lastSel = WIH_LAST;
    endcase
  end

  wload_ctr #(.W(AW)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (ctrClr),
    .inc_i   (ctrInc),
    .last_i  (lastSel),
    .count_o (ctrCount),
    .tc_o    (ctrTc)
  );

  // Load FSM with registered write strobe, address, data and done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      wrWih_q  <= 1'b0;
      wrWhh_q  <= 1'b0;
      wrBih_q  <= 1'b0;
      wrBhh_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      done_q   <= 1'b0;
    end else begin
      wrWih_q <= 1'b0;
      wrWhh_q <= 1'b0;
      wrBih_q <= 1'b0;
      wrBhh_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start && !abort) begin
          state_q <= ST_WIH;
          busy_q  <= 1'b1;
        end
      end else if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (accept) begin
        wrAddr_q <= ctrCount;
        wrData_q <= s_data;
        unique case (state_q)
          ST_WIH: begin
            wrWih_q <= 1'b1;
            if (ctrTc) state_q <= ST_WHH;
          end
          ST_WHH: begin
            wrWhh_q <= 1'b1;
            if (ctrTc) state_q <= ST_BIH;
          end
          ST_BIH: begin
            wrBih_q <= 1'b1;
            if (ctrTc) state_q <= ST_BHH;
          end
          ST_BHH: begin
            wrBhh_q <= 1'b1;
            if (ctrTc) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running sum: cleared when a load starts, one add per kept beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start && !abort) checksum_q <= '0;
    end else if (accept && !abort) begin
      checksum_q <= checksum_q + 32'(s_data);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign s_ready = busy_q;
  assign busy    = busy_q;
  assign wr_wih  = wrWih_q;
  assign wr_whh  = wrWhh_q;
  assign wr_bih  = wrBih_q;
  assign wr_bhh  = wrBhh_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign done    = done_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: scoreboard bench for weight_loader at col=4, cow=2
// (regions 32/64/16/16 words). Honours WLOAD_CHECKSUM_EN when defined.
module tb_weight_loader;

  localparam int COL   = 4;
  localparam int COW   = 2;
  localparam int QZ    = 16;
  localparam int L_WIH = COL * COW * 4;
  localparam int L_WHH = COL * COL * 4;
  localparam int L_B   = COL * 4;
  localparam int TOTAL = L_WIH + L_WHH + 2 * L_B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, s_valid;
  logic [QZ-1:0] s_data;
  logic          s_ready, wr_wih, wr_whh, wr_bih, wr_bhh, busy, done;
  logic [5:0]    wr_addr;
  logic [QZ-1:0] wr_data;
  logic [31:0]   checksum;

  typedef struct packed {
    logic [3:0]    strb;
    logic [5:0]    addr;
    logic [QZ-1:0] data;
    logic          done;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          startCyc = 0;
  int          doneCyc = 0;
  int          busyCount = 0;
  int          doneCount = 0;
  logic [31:0] expSum;

  weight_loader #(.col(COL), .cow(COW), .QZ(QZ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .wr_wih   (wr_wih),
    .wr_whh   (wr_whh),
    .wr_bih   (wr_bih),
    .wr_bhh   (wr_bhh),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time done relative to the start edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference placement of the k-th word of a load, from the region lengths
  function automatic exp_t refWord(input int k, input logic [QZ-1:0] d);
    exp_t e;
    e.data = d;
    e.done = (k == TOTAL - 1);
    if (k < L_WIH) begin
      e.strb = 4'b1000; e.addr = 6'(k);
    end else if (k < L_WIH + L_WHH) begin
      e.strb = 4'b0100; e.addr = 6'(k - L_WIH);
    end else if (k < L_WIH + L_WHH + L_B) begin
      e.strb = 4'b0010; e.addr = 6'(k - L_WIH - L_WHH);
    end else begin
      e.strb = 4'b0001; e.addr = 6'(k - L_WIH - L_WHH - L_B);
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a write or done
  always @(negedge clk) begin
    exp_t e;
    if (busy) busyCount++;
    if ({wr_wih, wr_whh, wr_bih, wr_bhh} != 4'b0 || done) begin
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (expQ.size() == 0) begin
        checkOutput("unexpected write", {wr_wih, wr_whh, wr_bih, wr_bhh, wr_addr, wr_data, done}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("write", {wr_wih, wr_whh, wr_bih, wr_bhh, wr_addr, wr_data, done}, e);
      end
    end
  end

  function automatic logic [31:0] expChecksum(input logic [31:0] s);
`ifdef WLOAD_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  // action: 0 normal, 1 abort at stopAt, 2 reset at stopAt, 3 re-pulse start at stopAt
  task automatic applyStimulus(input bit toggle, input bit countData, input int stopAt, input int action);
    int k;
    int doneBefore;
    doneBefore = doneCount;
    expSum = 32'd0;
    @(posedge clk); #1;
    busyCount = 0;
    start = 1'b1;
    @(posedge clk); #1;
    startCyc = cyc;
    start = 1'b0;
    k = 0;
    while (k < TOTAL) begin
      if (action == 1 && k == stopAt) begin
        abort = 1'b1; s_valid = 1'b1; s_data = QZ'($urandom);
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        break;
      end
      if (action == 2 && k == stopAt) begin
        s_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-load", {busy, s_ready, done, wr_wih, wr_whh, wr_bih, wr_bhh, wr_addr, wr_data, checksum}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expSum = 32'd0;
        break;
      end
      s_valid = 1'b1;
      s_data  = countData ? QZ'(k + 1) : QZ'($urandom);
      start   = (action == 3 && k == stopAt);
      expQ.push_back(refWord(k, s_data));
      expSum += 32'(s_data);
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (toggle) begin
        s_valid = 1'b0; s_data = QZ'($urandom);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("pending writes", 64'(expQ.size()), 64'd0);
    expQ.delete();
    checkOutput("busy after load", {busy, s_ready}, 64'd0);
    checkOutput("checksum", checksum, expChecksum(expSum));
    if (action == 0 || action == 3) begin
      checkOutput("done count", 64'(doneCount - doneBefore), 64'd1);
      checkOutput("done latency", 64'(doneCyc - startCyc), toggle ? 64'd255 : 64'd128);
      checkOutput("busy cycles", 64'(busyCount), toggle ? 64'd255 : 64'd128);
    end else begin
      checkOutput("no done", 64'(doneCount - doneBefore), 64'd0);
    end
  endtask

  // Hard stop in case a wait ever runs away
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset state", {busy, s_ready, done, wr_wih, wr_whh, wr_bih, wr_bhh, wr_addr, wr_data, checksum}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle: valid data, lone abort and start+abort together must not start a load
    s_valid = 1'b1; s_data = 16'h1234; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle start+abort ignored", {busy, s_ready}, 64'd0);

    applyStimulus(1'b0, 1'b1, 0, 0);
`ifdef WLOAD_CHECKSUM_EN
    checkOutput("checksum 1..128", checksum, 64'd8256);
`endif
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 40, 1);
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 100, 2);
    applyStimulus(1'b0, 1'b0, 50, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
